packet_forwarder: RTL and testbench

- Downstream consumer of the triple-buffered packet memory's forwarder port.
- When a buffer is handed over as accepted, the block reads it as 64-bit words and emits it on an AXI4-Stream-style master with tkeep/tlast.
- It then pulses forwarder_done to return the buffer to the snooper.
- Sits between the packet memory and the egress fabric.

---
 rtl/packet_forwarder_pkg.sv | 24 ++
 rtl/packet_forwarder_if.sv | 11 +
 rtl/packet_forwarder_fwd_out_fifo.sv | 35 +++
 rtl/packet_forwarder.sv | 123 ++++++++++++
 tb/tb_packet_forwarder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/packet_forwarder_pkg.sv
// Shared types for the packet forwarder: FSM encoding, beat size, output FIFO entry
// and the last-beat byte-enable helper.
package packet_forwarder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } fwd_state_e;

    localparam int BEAT_BYTES = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } fifo_entry_t;

    // First byte of the packet sits in the MSB lane, so a partial beat keeps the upper lanes.
    function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : ~(8'hFF >> rem);
    endfunction

endpackage

// File: rtl/packet_forwarder_if.sv
// AXI4-Stream style beat channel (64-bit data, MSB-first byte enables).
interface packet_forwarder_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/packet_forwarder_fwd_out_fifo.sv
// Two-entry output FIFO holding {data, keep, last}; the caller guarantees no push when full.
module fwd_out_fifo
    import packet_forwarder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t dout,
    output logic [1:0]  occ
);
    fifo_entry_t [1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/packet_forwarder.sv
// Reads an accepted packet buffer as 64-bit words and streams it out, then releases the buffer.
// Define FWD_STATS_EN to add the stat_pkts / stat_bytes counters.
module packet_forwarder
    import packet_forwarder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int PACKLEN_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ready_for_forwarder,
    input  logic [PACKLEN_WIDTH-1:0] len_to_forwarder,
    output logic [ADDR_WIDTH-1:0]    forwarder_rd_addr,
    output logic                     forwarder_rd_en,
    input  logic [63:0]              forwarder_rd_data,
    output logic                     forwarder_done,
`ifdef FWD_STATS_EN
    output logic [31:0]              stat_pkts,
    output logic [31:0]              stat_bytes,
`endif
    packet_forwarder_if.master       m_axis
);
    localparam logic [PACKLEN_WIDTH-1:0] MAXB = PACKLEN_WIDTH'(BEAT_BYTES) << (ADDR_WIDTH - 1);

    fwd_state_e               state, state_nxt;
    logic [PACKLEN_WIDTH-1:0] len_clamp;
    logic [2:0]               rem_q;
    logic [ADDR_WIDTH-1:0]    beats_q, issued, rd_idx;
    logic                     rd_vld;
    logic [1:0]               occ;
    logic                     tvalid, pop, start;
    fifo_entry_t              push_ent, head;

    assign len_clamp = (len_to_forwarder > MAXB) ? MAXB : len_to_forwarder;
    assign start     = (state == IDLE) && ready_for_forwarder;
    assign tvalid    = (state == STREAM) && (occ != 2'd0);
    assign pop       = tvalid && m_axis.tready;

    always_comb begin
        state_nxt       = state;
        forwarder_rd_en = 1'b0;
        forwarder_done  = 1'b0;
        unique case (state)
            IDLE: if (ready_for_forwarder)
                state_nxt = (len_to_forwarder == '0) ? DONE : STREAM;
            STREAM: begin
                // Never let queued plus in-flight beats exceed the two FIFO slots.
                forwarder_rd_en = (issued < beats_q) &&
                                  (({1'b0, occ} + 3'(rd_vld) - 3'(pop)) < 3'd2);
                if (pop && head.last) state_nxt = DONE;
            end
            DONE: begin
                forwarder_done = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign forwarder_rd_addr = forwarder_rd_en ? issued : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem_q   <= 3'd0;
            beats_q <= '0;
            issued  <= '0;
            rd_idx  <= '0;
            rd_vld  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= forwarder_rd_en;
            if (start) begin
                rem_q   <= len_clamp[2:0];
                beats_q <= ADDR_WIDTH'((len_clamp + PACKLEN_WIDTH'(BEAT_BYTES - 1)) >> 3);
                issued  <= '0;
            end else if (forwarder_rd_en) begin
                issued <= issued + ADDR_WIDTH'(1);
                rd_idx <= issued;
            end
        end
    end

    always_comb begin
        push_ent.data = forwarder_rd_data;
        push_ent.last = (rd_idx == beats_q - ADDR_WIDTH'(1));
        push_ent.keep = push_ent.last ? keep_from_rem(rem_q) : 8'hFF;
    end

    fwd_out_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_vld),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .occ   (occ)
    );

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = head.data;
    assign m_axis.tkeep  = head.keep;
    assign m_axis.tlast  = head.last;

`ifdef FWD_STATS_EN
    logic [PACKLEN_WIDTH-1:0] len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            stat_pkts  <= 32'd0;
            stat_bytes <= 32'd0;
        end else begin
            if (start) len_q <= len_clamp;
            if (state == DONE) begin
                stat_pkts  <= stat_pkts + 32'd1;
                stat_bytes <= stat_bytes + 32'(len_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed + randomized bench for packet_forwarder against a byte-level packet model.
// Stat counters are checked when FWD_STATS_EN is defined.
module tb_packet_forwarder;
    localparam int AW   = 10;
    localparam int PW   = 32;
    localparam int MAXB = 4096;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          ready  = 1'b0;
    logic [PW-1:0] len_in = '0;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [63:0]   rd_data = '0;
    logic          done;
`ifdef FWD_STATS_EN
    logic [31:0]   stat_pkts, stat_bytes;
`endif

    packet_forwarder_if m_axis();

    logic [63:0] mem [512];
    int          total = 0;
    int          bad   = 0;
    longint      exp_pkts  = 0;
    longint      exp_bytes = 0;

    packet_forwarder #(.ADDR_WIDTH(AW), .PACKLEN_WIDTH(PW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ready_for_forwarder (ready),
        .len_to_forwarder    (len_in),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (done),
`ifdef FWD_STATS_EN
        .stat_pkts           (stat_pkts),
        .stat_bytes          (stat_bytes),
`endif
        .m_axis              (m_axis)
    );

    always #5 clk = ~clk;

    // Memory responder: one-cycle read latency, garbage when not reading.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[8:0]] : {$urandom, $urandom};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {rd_en, done, m_axis.tvalid, m_axis.tlast, m_axis.tkeep, rd_addr}, 0);
        chk({tag, "_tdata"}, m_axis.tdata, 0);
`ifdef FWD_STATS_EN
        chk({tag, "_stats"}, {stat_pkts, stat_bytes}, 0);
`endif
    endtask

    function automatic int exp_beats(input int len);
        int c;
        c = (len > MAXB) ? MAXB : len;
        return (c + 7) / 8;
    endfunction

    function automatic logic [7:0] exp_keep(input int len, input int k);
        int c, nb, nv;
        logic [7:0] kp;
        c  = (len > MAXB) ? MAXB : len;
        nb = (c + 7) / 8;
        nv = (k == nb - 1) ? c - 8 * (nb - 1) : 8;
        kp = '0;
        for (int i = 0; i < 8; i++) if (i < nv) kp[7 - i] = 1'b1;
        return kp;
    endfunction

    // mode 0: tready high, 1: toggling, 2: random. abort_after>0 resets after that many beats.
    task automatic run_pkt(input int len, input int mode, input int abort_after);
        int          nb, clamp, iss, pops, cyc, last_hs, first_tv;
        bit          fin, prev_stall, prev_last;
        logic [7:0]  prev_keep;
        logic [63:0] prev_data;
        clamp = (len > MAXB) ? MAXB : len;
        nb    = exp_beats(len);
        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};

        @(posedge clk); #1;
        ready = 1'b1;
        len_in = len;
        m_axis.tready = 1'b1;
        @(negedge clk);
        chk("idle_quiet", {rd_en, m_axis.tvalid, done}, 0);
`ifdef FWD_STATS_EN
        chk("stat_pkts", stat_pkts, 64'(exp_pkts));
        chk("stat_bytes", stat_bytes, 64'(exp_bytes));
`endif
        iss = 0; pops = 0; cyc = 0; last_hs = -1; first_tv = -1;
        fin = 0; prev_stall = 0; prev_last = 0; prev_keep = '0; prev_data = '0;

        while (!fin && cyc < 4 * nb + 20) begin
            @(posedge clk); #1;
            ready  = 1'b0;
            len_in = $urandom;
            case (mode)
                0:       m_axis.tready = 1'b1;
                1:       m_axis.tready = (cyc % 2 == 0);
                default: m_axis.tready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);

            if (prev_stall) begin
                chk("stall_hold", {m_axis.tvalid, m_axis.tlast, m_axis.tkeep}, {1'b1, prev_last, prev_keep});
                chk("stall_data", m_axis.tdata, prev_data);
            end
            chk("outstanding", (iss - pops <= 2), 1);
            if (mode == 0) begin
                chk("rd_en_full_rate", rd_en, (iss < nb));
                chk("tvalid_full_rate", m_axis.tvalid, (cyc >= 2 && cyc < nb + 2));
            end
            if (rd_en) begin
                chk("rd_addr", rd_addr, iss);
                if (iss == 0) chk("first_rd_cyc", cyc, 0);
                iss++;
            end
            if (m_axis.tvalid) begin
                if (first_tv < 0) begin
                    first_tv = cyc;
                    chk("first_tvalid_cyc", cyc, 2);
                end
                if (m_axis.tready) begin
                    chk("tdata", m_axis.tdata, mem[pops % 512]);
                    chk("tkeep", m_axis.tkeep, exp_keep(len, pops));
                    chk("tlast", m_axis.tlast, (pops == nb - 1));
                    pops++;
                    last_hs = cyc;
                end
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_last  = m_axis.tlast;
            prev_keep  = m_axis.tkeep;
            prev_data  = m_axis.tdata;

            if (done) begin
                chk("done_beats", pops, nb);
                chk("done_cyc", cyc, (nb == 0) ? 0 : last_hs + 1);
                chk("done_tvalid", m_axis.tvalid, 0);
                exp_pkts++;
                exp_bytes += clamp;
                fin = 1;
            end else if (abort_after > 0 && pops == abort_after) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort_immediate");
                @(posedge clk); #1;
                chk_zero("abort_held");
                @(negedge clk);
                rst_n = 1'b1;
                exp_pkts  = 0;
                exp_bytes = 0;
                fin = 1;
            end
            cyc++;
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        m_axis.tready = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        chk_zero("reset_hold");
        rst_n = 1'b1;

        run_pkt(20, 0, 0);
        run_pkt(16, 1, 0);
        run_pkt(0, 0, 0);
        run_pkt(9000, 2, 0);
        run_pkt(40, 0, 2);
        run_pkt(8, 0, 0);
        run_pkt(24, 0, 0);
        run_pkt(1, 0, 0);
        for (int n = 0; n < 8; n++) run_pkt(int'($urandom_range(0, 100)), int'($urandom_range(0, 2)), 0);

        @(posedge clk); #1;
        @(negedge clk);
        chk("done_single_cycle", done, 0);
`ifdef FWD_STATS_EN
        chk("final_stat_pkts", stat_pkts, 64'(exp_pkts));
        chk("final_stat_bytes", stat_bytes, 64'(exp_bytes));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
